edf_arbiter: RTL

- Sits directly downstream of the gateway cell array. Consumes each cell's pending flag and absolute deadline.
- Selects the pending interrupt with the earliest deadline by sequentially scanning the cells, one per cycle.
- Offers the winner to the core over a valid/ready handshake.
- On acceptance, pulses a one-hot claim back to the winning gateway cell so that cell clears its pending state.

---
 rtl/edf_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first interrupt arbiter: scans the gateway cells one per cycle,
// offers the earliest pending deadline to the core and pulses a claim back on acceptance.
module edf_arbiter #(
  parameter int NrIrqs  = 4,
  parameter int TsWidth = 64,
  localparam int IdWidth = $clog2(NrIrqs)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NrIrqs-1:0]         ip_i,
  input  logic [NrIrqs*TsWidth-1:0] dl_i,
  output logic [IdWidth-1:0]        irq_id_o,
  output logic                      irq_valid_o,
  input  logic                      irq_ready_i,
  output logic [NrIrqs-1:0]         claim_o,
  output logic                      busy_o,
  output logic [1:0]                dbg_state_o
);

  // Handshake: an offer is transferred on a cycle where irq_valid_o and irq_ready_i
  // are both high; once raised, irq_valid_o and irq_id_o hold until that cycle, and
  // irq_ready_i has no effect while irq_valid_o is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2,
    CLAIM = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IdWidth-1:0]   idx_q;
  logic                 best_valid_q;
  logic [IdWidth-1:0]   best_id_q;
  logic [TsWidth-1:0]   best_dl_q;

  logic [TsWidth-1:0]   cur_dl;
  logic                 take;
  logic                 last;

  // Only the currently scanned cell is sampled; strict compare keeps the lower index on ties.
  assign cur_dl = dl_i[int'(idx_q)*TsWidth +: TsWidth];
  assign take   = ip_i[idx_q] & (~best_valid_q | (cur_dl < best_dl_q));
  assign last   = (idx_q == IdWidth'(NrIrqs - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|ip_i) state_d = SCAN;
      SCAN:    if (last) state_d = (best_valid_q | take) ? OFFER : IDLE;
      OFFER:   if (irq_ready_i) state_d = CLAIM;
      CLAIM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q        <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_dl_q    <= '0;
    end else if (state_q == IDLE) begin
      idx_q        <= '0;
      best_valid_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (take) begin
        best_valid_q <= 1'b1;
        best_id_q    <= idx_q;
        best_dl_q    <= cur_dl;
      end
      if (!last) idx_q <= idx_q + 1'b1;
    end
  end

  assign irq_valid_o = (state_q == OFFER);
  assign irq_id_o    = (state_q == OFFER) ? best_id_q : '0;
  assign claim_o     = (state_q == CLAIM) ? ({{(NrIrqs-1){1'b0}}, 1'b1} << best_id_q) : '0;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
